// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decode/issue slot in front of the execute-stage ALU.
// Decodes an RV32I instruction into a 4-bit ALU control code and both ALU
// operands, then holds them in a single-entry valid/ready register slot.
// The slot can stall, drain, accept back-to-back and be flushed.
module alu_issue_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_control,
    output logic [XLEN-1:0] left_operand,
    output logic [XLEN-1:0] right_operand,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rd,
    output logic            out_is_branch,
    output logic            out_illegal
);

    // ALU control encodings shared with the execute stage.
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] B_BNE    = 4'd10;
    localparam logic [3:0] B_BLT    = 4'd11;
    localparam logic [3:0] B_BGE    = 4'd12;
    localparam logic [3:0] B_LTU    = 4'd13;
    localparam logic [3:0] B_GEU    = 4'd14;

    // RV32I major opcodes.
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // Register/immediate ALU operation from funct3; alt selects SUB or SRA.
    function automatic logic [3:0] alu_sel(input logic [2:0] f3, input logic alt);
        logic [3:0] sel;
        unique case (f3)
            3'b000:  sel = alt ? ALU_SUB : ALU_ADD;
            3'b001:  sel = ALU_SLL;
            3'b010:  sel = ALU_SLT;
            3'b011:  sel = ALU_SLTU;
            3'b100:  sel = ALU_XOR;
            3'b101:  sel = alt ? ALU_SRA : ALU_SRL;
            3'b110:  sel = ALU_OR;
            default: sel = ALU_AND;
        endcase
        return sel;
    endfunction

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic            w_alt;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_shamt;

    logic [3:0]      w_ctl;
    logic [XLEN-1:0] w_left;
    logic [XLEN-1:0] w_right;
    logic [4:0]      w_rd;
    logic            w_branch;
    logic            w_illegal;
    logic            w_load;

    logic            r_valid;
    logic [3:0]      r_ctl;
    logic [XLEN-1:0] r_left;
    logic [XLEN-1:0] r_right;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_pc;
    logic [4:0]      r_rd;
    logic            r_branch;
    logic            r_illegal;

    assign w_opcode = in_instr[6:0];
    assign w_funct3 = in_instr[14:12];
    assign w_alt    = in_instr[30];
    assign w_imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
    assign w_imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign w_imm_u  = {in_instr[31:12], 12'b0};
    assign w_shamt  = {27'b0, in_instr[24:20]};

    // Instruction decode: pure selection of control code and operand sources.
    always_comb begin
        w_ctl     = ALU_ADD;
        w_left    = '0;
        w_right   = '0;
        w_rd      = '0;
        w_branch  = 1'b0;
        w_illegal = 1'b0;
        unique case (w_opcode)
            OPC_OP: begin
                w_ctl   = alu_sel(w_funct3, w_alt);
                w_left  = in_rs1_data;
                w_right = in_rs2_data;
                w_rd    = in_instr[11:7];
            end
            OPC_OPIMM: begin
                // ADDI never subtracts; only the shift-right slot uses bit 30.
                w_ctl   = alu_sel(w_funct3, w_alt && (w_funct3 == 3'b101));
                w_left  = in_rs1_data;
                w_right = (w_funct3[1:0] == 2'b01) ? w_shamt : w_imm_i;
                w_rd    = in_instr[11:7];
            end
            OPC_LOAD: begin
                w_left  = in_rs1_data;
                w_right = w_imm_i;
                w_rd    = in_instr[11:7];
            end
            OPC_STORE: begin
                w_left  = in_rs1_data;
                w_right = w_imm_s;
            end
            OPC_BRANCH: begin
                if (w_funct3[2:1] == 2'b01) begin
                    w_illegal = 1'b1;
                end else begin
                    w_branch = 1'b1;
                    w_left   = in_rs1_data;
                    w_right  = in_rs2_data;
                    unique case (w_funct3)
                        3'b000:  w_ctl = ALU_SUB;
                        3'b001:  w_ctl = B_BNE;
                        3'b100:  w_ctl = B_BLT;
                        3'b101:  w_ctl = B_BGE;
                        3'b110:  w_ctl = B_LTU;
                        default: w_ctl = B_GEU;
                    endcase
                end
            end
            OPC_LUI: begin
                w_right = w_imm_u;
                w_rd    = in_instr[11:7];
            end
            OPC_AUIPC: begin
                w_left  = in_pc;
                w_right = w_imm_u;
                w_rd    = in_instr[11:7];
            end
            OPC_JAL, OPC_JALR: begin
                // ALU produces the link value pc + 4.
                w_left  = in_pc;
                w_right = 32'd4;
                w_rd    = in_instr[11:7];
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign in_ready = !r_valid || out_ready;
    assign w_load   = in_valid && in_ready && !flush;

    // Slot occupancy: flush empties, load fills, consume without refill drains.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Issued instruction payload; only written on an accepted load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_ctl     <= ALU_ADD;
            r_left    <= '0;
            r_right   <= '0;
            r_rs2     <= '0;
            r_pc      <= RESET_PC;
            r_rd      <= '0;
            r_branch  <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_load) begin
            r_ctl     <= w_ctl;
            r_left    <= w_left;
            r_right   <= w_right;
            r_rs2     <= in_rs2_data;
            r_pc      <= in_pc;
            r_rd      <= w_rd;
            r_branch  <= w_branch;
            r_illegal <= w_illegal;
        end
    end

    assign out_valid     = r_valid;
    assign alu_control   = r_ctl;
    assign left_operand  = r_left;
    assign right_operand = r_right;
    assign out_rs2_data  = r_rs2;
    assign out_pc        = r_pc;
    assign out_rd        = r_rd;
    assign out_is_branch = r_branch;
    assign out_illegal   = r_illegal;

endmodule
